// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the fetch/execute sequencer and its PC unit.
package exec_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [5:0]  HALT_OPCODE  = 6'h3F;

  // Jump destinations are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/exec_sequencer_pc_unit.sv
// Program counter with a one-instruction branch delay slot.
module pc_unit
  import exec_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] pc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] delay_target_q, delay_target_d;
  logic        delay_pending_q, delay_pending_d;

  always_comb begin
    pc_d            = pc_q;
    delay_target_d  = delay_target_q;
    delay_pending_d = delay_pending_q;
    if (advance) begin
      if (delay_pending_q) begin
        pc_d            = delay_target_q;
        delay_pending_d = 1'b0;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
      // A branch sitting in a delay slot queues its own target behind the one just applied.
      if (branch) begin
        delay_pending_d = 1'b1;
        delay_target_d  = word_align(branch_target);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_VECTOR;
      delay_target_q  <= 32'd0;
      delay_pending_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      delay_target_q  <= delay_target_d;
      delay_pending_q <= delay_pending_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/exec_sequencer.sv
// Two-phase fetch/execute sequencer with memory wait handling and halt.
//   state     | meaning
//   ST_FETCH  | instruction read in flight, IR loads when imem is ready
//   ST_EXEC   | decoded instruction runs; data access waits, then commits
//   ST_HALTED | halt retired; everything idle until reset
module exec_sequencer
  import exec_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_waitrequest,
  input  logic        dmem_waitrequest,
  input  logic        ctrl_mem_read,
  input  logic        ctrl_mem_write,
  input  logic        ctrl_branch,
  input  logic        ctrl_halt,
  input  logic [31:0] branch_target,
  output logic        state,
  output logic [31:0] pc,
  output logic        imem_read,
  output logic        ir_en,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        commit,
  output logic        active
);

  seq_state_e state_q, state_d;
  logic imem_read_c, ir_en_c, dmem_read_c, dmem_write_c, commit_c;

  always_comb begin
    state_d      = state_q;
    imem_read_c  = 1'b0;
    ir_en_c      = 1'b0;
    dmem_read_c  = 1'b0;
    dmem_write_c = 1'b0;
    commit_c     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_read_c = 1'b1;
        if (!imem_waitrequest) begin
          ir_en_c = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl_halt) begin
          state_d = ST_HALTED;
        end else begin
          // Simultaneous read and write decodes are handled as a store.
          dmem_write_c = ctrl_mem_write;
          dmem_read_c  = ctrl_mem_read & ~ctrl_mem_write;
          if (!((ctrl_mem_read | ctrl_mem_write) && dmem_waitrequest)) begin
            commit_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  pc_unit u_pc_unit (
    .clk           (clk),
    .reset         (reset),
    .advance       (commit_c & ~reset),
    .branch        (ctrl_branch),
    .branch_target (branch_target),
    .pc            (pc)
  );

  // Strobes are masked while reset is held so nothing leaks out mid-reset.
  assign imem_read  = imem_read_c  & ~reset;
  assign ir_en      = ir_en_c      & ~reset;
  assign dmem_read  = dmem_read_c  & ~reset;
  assign dmem_write = dmem_write_c & ~reset;
  assign commit     = commit_c     & ~reset;
  assign state      = (state_q == ST_EXEC);
  assign active     = (state_q != ST_HALTED);

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench: instruction table, corner-case sequences and a randomized program vs. a PC model.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_waitrequest = 1'b0;
  logic        dmem_waitrequest = 1'b0;
  logic        ctrl_mem_read = 1'b0;
  logic        ctrl_mem_write = 1'b0;
  logic        ctrl_branch = 1'b0;
  logic        ctrl_halt = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        state, imem_read, ir_en, dmem_read, dmem_write, commit, active;
  logic [31:0] pc;

  exec_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .imem_waitrequest (imem_waitrequest),
    .dmem_waitrequest (dmem_waitrequest),
    .ctrl_mem_read    (ctrl_mem_read),
    .ctrl_mem_write   (ctrl_mem_write),
    .ctrl_branch      (ctrl_branch),
    .ctrl_halt        (ctrl_halt),
    .branch_target    (branch_target),
    .state            (state),
    .pc               (pc),
    .imem_read        (imem_read),
    .ir_en            (ir_en),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .commit           (commit),
    .active           (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          fw;
    logic        rd;
    logic        wr;
    logic        br;
    logic        halt;
    int          dw;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {25'd0, state, imem_read, ir_en, dmem_read, dmem_write, commit, active};
  endfunction

  function automatic logic [31:0] flags(input logic st, input logic ir, input logic ie,
                                        input logic dr, input logic dwr, input logic cm,
                                        input logic ac);
    return {25'd0, st, ir, ie, dr, dwr, cm, ac};
  endfunction

  function automatic vec_t mk(input int fw, input logic rd, input logic wr, input logic br,
                              input logic halt, input int dw, input logic [31:0] tgt,
                              input logic [31:0] exp_pc);
    vec_t v;
    v.fw = fw; v.rd = rd; v.wr = wr; v.br = br; v.halt = halt;
    v.dw = dw; v.tgt = tgt; v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic clear_inputs();
    imem_waitrequest = 1'b0; dmem_waitrequest = 1'b0;
    ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0;
    ctrl_branch = 1'b0; ctrl_halt = 1'b0; branch_target = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    #1;
    chk("reset_flags", obs(), flags(0, 0, 0, 0, 0, 0, 1));
    chk("reset_pc", pc, 32'hBFC0_0000);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("release_flags", obs(), flags(0, 1, 1, 0, 0, 0, 1));
    chk("release_pc", pc, 32'hBFC0_0000);
  endtask

  task automatic fetch_phase(input int fw, input logic [31:0] exp_pc);
    for (int k = 0; k <= fw; k++) begin
      @(negedge clk);
      imem_waitrequest = (k < fw);
      ctrl_mem_read = 1'($urandom); ctrl_mem_write = 1'($urandom);
      ctrl_branch = 1'($urandom); ctrl_halt = 1'($urandom);
      dmem_waitrequest = 1'($urandom); branch_target = $urandom;
      #1;
      chk("fetch_flags", obs(), flags(0, 1, (k == fw), 0, 0, 0, 1));
      chk("fetch_pc", pc, exp_pc);
    end
  endtask

  task automatic run_instr(input vec_t v);
    int n;
    fetch_phase(v.fw, v.exp_pc);
    if (v.halt) begin
      @(negedge clk);
      ctrl_halt = 1'b1;
      ctrl_mem_read = 1'($urandom); ctrl_mem_write = 1'($urandom);
      ctrl_branch = 1'($urandom); branch_target = $urandom;
      imem_waitrequest = 1'($urandom); dmem_waitrequest = 1'($urandom);
      #1;
      chk("halt_exec_flags", obs(), flags(1, 0, 0, 0, 0, 0, 1));
      chk("halt_exec_pc", pc, v.exp_pc);
      return;
    end
    n = (v.rd || v.wr) ? v.dw : 0;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      ctrl_halt = 1'b0;
      ctrl_mem_read = v.rd; ctrl_mem_write = v.wr;
      ctrl_branch = v.br; branch_target = v.tgt;
      imem_waitrequest = 1'($urandom);
      dmem_waitrequest = (v.rd || v.wr) ? (k < v.dw) : 1'($urandom);
      #1;
      chk("exec_flags", obs(), flags(1, 0, 0, v.rd & ~v.wr, v.wr, (k == n), 1));
      chk("exec_pc", pc, v.exp_pc);
    end
  endtask

  task automatic check_halted(input int cycles, input logic [31:0] exp_pc);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      imem_waitrequest = 1'($urandom); dmem_waitrequest = 1'($urandom);
      ctrl_mem_read = 1'($urandom); ctrl_mem_write = 1'($urandom);
      ctrl_branch = 1'($urandom); ctrl_halt = 1'($urandom);
      branch_target = $urandom;
      #1;
      chk("halted_flags", obs(), flags(0, 0, 0, 0, 0, 0, 0));
      chk("halted_pc", pc, exp_pc);
    end
  endtask

  vec_t tbl[15];

  initial begin
    logic [31:0] m_pc, m_tgt;
    logic        m_pend;
    vec_t        v;
    int          op;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'hBFC0_0000);
    tbl[1]  = mk(3, 0, 0, 0, 0, 0, 32'h0,         32'hBFC0_0004);
    tbl[2]  = mk(0, 1, 0, 0, 0, 2, 32'h0,         32'hBFC0_0008);
    tbl[3]  = mk(1, 1, 1, 0, 0, 1, 32'h0,         32'hBFC0_000C);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 32'h0000_0103, 32'hBFC0_0010);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'hBFC0_0014);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0000_0100);
    tbl[7]  = mk(2, 0, 0, 1, 0, 0, 32'h0000_0200, 32'h0000_0104);
    tbl[8]  = mk(0, 1, 0, 1, 0, 1, 32'h0000_0301, 32'h0000_0108);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0200);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0300);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'h0000_0304);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0308);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000);

    #3;
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(tbl[i]);

    // Halt at the third instruction address.
    do_reset();
    run_instr(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hBFC0_0000));
    run_instr(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hBFC0_0004));
    run_instr(mk(0, 0, 0, 1, 1, 0, 32'h1234, 32'hBFC0_0008));
    check_halted(10, 32'hBFC0_0008);

    // Reset asserted while a store is stalled on dmem.
    do_reset();
    run_instr(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hBFC0_0000));
    run_instr(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hBFC0_0004));
    fetch_phase(0, 32'hBFC0_0008);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      clear_inputs();
      ctrl_mem_write = 1'b1; dmem_waitrequest = 1'b1;
      #1;
      chk("store_wait_flags", obs(), flags(1, 0, 0, 0, 1, 0, 1));
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_flags", obs(), flags(0, 0, 0, 0, 0, 0, 1));
    chk("midreset_pc", pc, 32'hBFC0_0000);
    @(posedge clk);
    clear_inputs();
    #2 reset = 1'b0;
    run_instr(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hBFC0_0000));
    run_instr(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hBFC0_0004));

    // Randomized program against a per-instruction PC model.
    do_reset();
    m_pc = 32'hBFC0_0000; m_pend = 1'b0; m_tgt = 32'd0;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      v = mk($urandom_range(0, 2), op[0], op[1], ($urandom_range(0, 2) == 0), 1'b0,
             $urandom_range(0, 2), $urandom, m_pc);
      run_instr(v);
      if (m_pend) begin
        m_pc = m_tgt;
        m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      if (v.br) begin
        m_pend = 1'b1;
        m_tgt = {v.tgt[31:2], 2'b00};
      end
    end
    run_instr(mk(1, 0, 0, 0, 1, 0, 32'h0, m_pc));
    check_halted(5, m_pc);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL provide port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 The block SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL provide port imem_waitrequest, input, 1, instruction memory not ready; hold request.
REQ-004 The block SHALL provide port dmem_waitrequest, input, 1, data memory not ready; hold request.
REQ-005 The block SHALL provide ports ctrl_mem_read and ctrl_mem_write, input, 1 each, decoded load/store of the current instruction, valid in EXEC.
REQ-006 The block SHALL provide ports ctrl_branch and ctrl_halt, input, 1 each, decoded jump and halt (opcode 6'h3F), valid in EXEC.
REQ-007 The block SHALL provide port branch_target, input, 32, jump destination, valid when ctrl_branch=1.
REQ-008 The block SHALL provide port state, output, 1, 0=fetch phase, 1=execute phase; drives the control decoder's state input.
REQ-009 The block SHALL provide port pc, output, 32, current instruction address.
REQ-010 The block SHALL provide ports imem_read and ir_en, output, 1 each, instruction read strobe and one-cycle instruction-register load.
REQ-011 The block SHALL provide ports dmem_read and dmem_write, output, 1 each, data memory strobes.
REQ-012 The block SHALL provide port commit, output, 1, one-cycle pulse enabling register-file write and retirement.
REQ-013 The block SHALL provide port active, output, 1, high until halt.

Function
REQ-014 FSM states SHALL be FETCH, EXEC, HALTED; state output =1 only in EXEC.
REQ-015 FETCH: imem_read=1; if imem_waitrequest=1 remain FETCH, ir_en=0; else ir_en=1 for that cycle and next state EXEC.
REQ-016 EXEC with ctrl_halt=1: next state HALTED, commit=0, no memory strobe, pc unchanged; halt has priority over branch and memory.
REQ-017 EXEC with ctrl_mem_read or ctrl_mem_write: matching dmem strobe held high each EXEC cycle; while dmem_waitrequest=1 remain EXEC, commit=0, pc unchanged.
REQ-018 EXEC completion (no halt, and no memory op or dmem_waitrequest=0): commit=1 for that cycle, next state FETCH, pc updated per REQ-019.
REQ-019 PC update at completion: if delay_pending, pc<=delay_target and delay_pending<=0; else pc<=pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-020 ctrl_branch at completion SHALL set delay_pending<=1, delay_target<={branch_target[31:2],2'b00} (MIPS branch delay slot: one following instruction executes first).
REQ-021 Branch in a delay slot: pending target applied to pc this completion; new target becomes pending.
REQ-022 ctrl_mem_read and ctrl_mem_write both high SHALL be treated as a store only (dmem_read=0).
REQ-023 HALTED: absorbing until reset; active=0, all strobes, ir_en, commit =0; pc frozen.
REQ-024 Minimum latency 2 cycles per instruction; each wait cycle adds one.

Reset
REQ-025 On reset assertion, asynchronously: state FETCH, pc=32'hBFC0_0000, delay_pending=0, delay_target=0, active=1, imem_read=1 after release, all other outputs 0.
REQ-026 Reset during any wait SHALL drop dmem strobes immediately; no commit issued.

Structure
REQ-027 Shared package SHALL hold state enum, RESET_VECTOR=32'hBFC0_0000, PC_STEP=4, HALT_OPCODE=6'h3F.
REQ-028 One sub-module pc_unit SHALL own pc, delay_pending, delay_target; FSM stays in exec_sequencer.

Verification
REQ-029 Reset release, no waits, three non-branch instructions -> pc 0xBFC00000, 0xBFC00004, 0xBFC00008; commit every 2nd cycle.
REQ-030 imem_waitrequest high 3 cycles -> FETCH held, imem_read high 4 cycles, ir_en single pulse on 4th.
REQ-031 Load with dmem_waitrequest high 2 cycles -> dmem_read high 3 cycles, commit one pulse on last, pc+4 after.
REQ-032 JR at pc=0xBFC00010, target 0x00000103 -> next pc 0xBFC00014, then 0x00000100.
REQ-033 Halt at 0xBFC00008 -> HALTED, active=0, no commit, pc stays 0xBFC00008 for 10 cycles.
REQ-034 Reset asserted mid store wait -> dmem_write drops same cycle, pc=0xBFC00000, state FETCH.
